// File: rtl/genius_round_ctrl_if.sv
// rtl/genius_round_ctrl_if.sv - handshake/bus bundle between the memory-game controller and its front end
//
// Signals:
//   start      one-cycle pulse, begins a new game
//   tick       one-cycle time-base enable
//   btn_valid  one-cycle pulse, btn holds a press
//   btn        player input, P_DATA bits
//   rom_data   ROM word at rom_addr (asynchronous-read ROM), P_DATA bits
//   rom_addr   ROM address, P_ADDR bits
//   led        LED drive, P_DATA bits
//   round      current round (1-based), P_ADDR bits
//   busy       game in progress
//   win        sticky, all rounds done
//   lose       sticky, wrong press or timeout
// Modports: master = front end / ROM side, slave = controller side.
interface genius_round_ctrl_if #(
   parameter int P_ADDR = 4,
   parameter int P_DATA = 4
);
   logic              start;
   logic              tick;
   logic              btn_valid;
   logic [P_DATA-1:0] btn;
   logic [P_DATA-1:0] rom_data;
   logic [P_ADDR-1:0] rom_addr;
   logic [P_DATA-1:0] led;
   logic [P_ADDR-1:0] round;
   logic              busy;
   logic              win;
   logic              lose;

   modport master (
      output start, tick, btn_valid, btn, rom_data,
      input  rom_addr, led, round, busy, win, lose
   );

   modport slave (
      input  start, tick, btn_valid, btn, rom_data,
      output rom_addr, led, round, busy, win, lose
   );
endinterface

// File: rtl/genius_round_ctrl.sv
// rtl/genius_round_ctrl.sv - round-sequencing FSM for the memory-game datapath
//
// Ports:
//   clk   system clock, rising edge
//   R     asynchronous active-low reset
//   bus   genius_round_ctrl_if.slave: start/tick/btn_valid/btn/rom_data in,
//         rom_addr/led/round/busy/win/lose out (all outputs registered)
// Optional feature: define GENIUS_TIMEOUT_EN to lose the game after
// P_TIMEOUT_TICKS tick pulses without a press in USER.
module genius_round_ctrl #(
   parameter int P_ADDR          = 4,
   parameter int P_DATA          = 4,
   parameter int P_MAX_ROUND     = 15,
   parameter int P_SHOW_TICKS    = 2,
   parameter int P_TIMEOUT_TICKS = 8
) (
   input logic               clk,
   input logic               R,
   genius_round_ctrl_if.slave bus
);

   localparam int CW = P_ADDR + 1;
   localparam logic [P_ADDR-1:0] ADDR_ONE  = P_ADDR'(1);
   localparam logic [P_ADDR-1:0] MAX_ROUND = P_ADDR'(P_MAX_ROUND);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]     SHOW_LAST = CW'(P_SHOW_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE, SHOW_ON, SHOW_OFF, USER, CHECK, NEXT, WIN, LOSE
   } state_t;

   state_t            state;
   logic [CW-1:0]     tick_cnt;
   logic [P_DATA-1:0] user_q;
   logic [P_ADDR-1:0] rom_addr_q;
   logic [P_ADDR-1:0] round_q;
   logic [P_DATA-1:0] led_q;
   logic              busy_q;
   logic              win_q;
   logic              lose_q;
   logic [P_ADDR-1:0] last_idx;

   // Index of the final element of the current round's sequence.
   assign last_idx = round_q - ADDR_ONE;

`ifdef GENIUS_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(P_TIMEOUT_TICKS - 1);
`else
   logic unused_timeout;
   assign unused_timeout = ^P_TIMEOUT_TICKS;
`endif

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         user_q     <= '0;
         rom_addr_q <= '0;
         round_q    <= '0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         case (state)
            IDLE, WIN, LOSE: begin
               if (bus.start) begin
                  round_q    <= ADDR_ONE;
                  rom_addr_q <= '0;
                  win_q      <= 1'b0;
                  lose_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  tick_cnt   <= '0;
                  state      <= SHOW_ON;
               end
            end

            SHOW_ON: begin
               // led follows the ROM one cycle behind the state.
               led_q <= bus.rom_data;
               if (bus.tick) begin
                  if (tick_cnt == SHOW_LAST) begin
                     tick_cnt <= '0;
                     state    <= SHOW_OFF;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_ONE;
                  end
               end
            end

            SHOW_OFF: begin
               led_q <= '0;
               if (bus.tick) begin
                  tick_cnt <= '0;
                  if (rom_addr_q == last_idx) begin
                     rom_addr_q <= '0;
                     state      <= USER;
                  end else begin
                     rom_addr_q <= rom_addr_q + ADDR_ONE;
                     state      <= SHOW_ON;
                  end
               end
            end

            USER: begin
               // A press takes priority over a coincident tick.
               if (bus.btn_valid) begin
                  user_q   <= bus.btn;
                  tick_cnt <= '0;
                  state    <= CHECK;
               end
`ifdef GENIUS_TIMEOUT_EN
               else if (bus.tick) begin
                  if (tick_cnt == TO_LAST) begin
                     tick_cnt <= '0;
                     lose_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state    <= LOSE;
                  end else begin
                     tick_cnt <= tick_cnt + CNT_ONE;
                  end
               end
`endif
            end

            CHECK: begin
               if (user_q != bus.rom_data) begin
                  lose_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= LOSE;
               end else if (rom_addr_q != last_idx) begin
                  rom_addr_q <= rom_addr_q + ADDR_ONE;
                  state      <= USER;
               end else if (round_q == MAX_ROUND) begin
                  win_q  <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= WIN;
               end else begin
                  state <= NEXT;
               end
            end

            NEXT: begin
               round_q    <= round_q + ADDR_ONE;
               rom_addr_q <= '0;
               state      <= SHOW_ON;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.led      = led_q;
   assign bus.round    = round_q;
   assign bus.busy     = busy_q;
   assign bus.win      = win_q;
   assign bus.lose     = lose_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// tb/tb_genius_round_ctrl.sv - scoreboard testbench for genius_round_ctrl
module tb_genius_round_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   genius_round_ctrl_if #(.P_ADDR(4), .P_DATA(4)) bus ();

   logic [3:0] rom [16];
   assign bus.rom_data = rom[bus.rom_addr];

   genius_round_ctrl #(
      .P_ADDR(4), .P_DATA(4), .P_MAX_ROUND(2),
      .P_SHOW_TICKS(2), .P_TIMEOUT_TICKS(3)
   ) dut (
      .clk(clk),
      .R(rst_n),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // Observation word: {led[3:0], round[3:0], busy, win, lose}
   logic [10:0] exp_q[$];
   logic        mon_en = 1'b0;
   logic [10:0] mon_prev;
   logic [10:0] mon_cur;
   logic [10:0] mon_exp;
   logic        tick_en = 1'b0;

   function automatic logic [10:0] snap(input logic [3:0] l, input logic [3:0] r,
                                         input logic b, input logic w, input logic lo);
      return {l, r, b, w, lo};
   endfunction

   task automatic push(input logic [3:0] l, input logic [3:0] r,
                       input logic b, input logic w, input logic lo);
      exp_q.push_back(snap(l, r, b, w, lo));
   endtask

   task automatic check(input string name, input int act, input int want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, act, want);
      end
   endtask

   // Monitor: every change in the observed outputs is one scoreboard event.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {bus.led, bus.round, bus.busy, bus.win, bus.lose};
         if (mon_cur !== mon_prev) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event got led=%h round=%0d busy=%b win=%b lose=%b expected=none",
                        mon_cur[10:7], mon_cur[6:3], mon_cur[2], mon_cur[1], mon_cur[0]);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_cur !== mon_exp) begin
                  fails++;
                  $display("FAIL scoreboard got led=%h round=%0d busy=%b win=%b lose=%b expected led=%h round=%0d busy=%b win=%b lose=%b",
                           mon_cur[10:7], mon_cur[6:3], mon_cur[2], mon_cur[1], mon_cur[0],
                           mon_exp[10:7], mon_exp[6:3], mon_exp[2], mon_exp[1], mon_exp[0]);
               end
            end
            mon_prev = mon_cur;
         end
      end
   end

   // Tick: one cycle high every 4 cycles once enabled.
   initial begin
      int tc;
      tc = 0;
      bus.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tick = tick_en && (tc == 3);
         tc = (tc + 1) % 4;
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
   endtask

   task automatic press(input logic [3:0] v);
      @(posedge clk); #1; bus.btn = v; bus.btn_valid = 1'b1;
      @(posedge clk); #1; bus.btn_valid = 1'b0;
   endtask

   // Returns on the edge where the controller enters USER: after 'falls'
   // LED blanking events, the next tick ends playback.
   task automatic wait_user(input int falls);
      int seen;
      int n;
      logic [3:0] prev_led;
      seen = 0;
      n = 0;
      @(negedge clk);
      prev_led = bus.led;
      while (seen < falls && n < 400) begin
         @(negedge clk);
         n++;
         if (prev_led != 4'd0 && bus.led == 4'd0) seen++;
         prev_led = bus.led;
      end
      while (!bus.tick && n < 400) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 400) begin
         fails++;
         $display("FAIL wait_user got=timeout expected=%0d playback elements", falls);
      end
      @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=time_limit expected=finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 16; i++) rom[i] = 4'd0;
      rom[0] = 4'b0001;
      rom[1] = 4'b0100;
      rom[2] = 4'b0010;
      bus.start = 1'b0;
      bus.btn_valid = 1'b0;
      bus.btn = 4'd0;
      rst_n = 1'b0;

      // Reset held with start/btn_valid toggling
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.start = ~bus.start;
         bus.btn_valid = ~bus.btn_valid;
      end
      check("rst_led", bus.led, 0);
      check("rst_round", bus.round, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_win", bus.win, 0);
      check("rst_lose", bus.lose, 0);
      check("rst_rom_addr", bus.rom_addr, 0);
      bus.start = 1'b0;
      bus.btn_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_round", bus.round, 0);

      mon_prev = 11'd0;
      mon_en = 1'b1;
      tick_en = 1'b1;

      // Game 1: round 1 correct, round 2 wrong press
      push(4'b0001 & 4'd0, 4'd1, 1, 0, 0);
      push(4'b0001, 4'd1, 1, 0, 0);
      push(4'd0, 4'd1, 1, 0, 0);
      pulse_start();
      wait_user(1);
      push(4'd0, 4'd2, 1, 0, 0);
      push(4'b0001, 4'd2, 1, 0, 0);
      push(4'd0, 4'd2, 1, 0, 0);
      push(4'b0100, 4'd2, 1, 0, 0);
      push(4'd0, 4'd2, 1, 0, 0);
      press(4'b0001);
      wait_user(2);
      check("round2", bus.round, 2);
      press(4'b0001);
      repeat (2) @(posedge clk);
      push(4'd0, 4'd2, 0, 0, 1);
      press(4'b0010);
      check("lose_in_check", bus.lose, 0);
      @(posedge clk); #1;
      check("lose_after_2", bus.lose, 1);
      check("busy_after_lose", bus.busy, 0);
      press(4'b0100);
      press(4'b0001);
      repeat (3) @(posedge clk);
      #1;
      check("lose_sticky", bus.lose, 1);

      // Game 2: win with P_MAX_ROUND=2
      push(4'd0, 4'd1, 1, 0, 0);
      push(4'b0001, 4'd1, 1, 0, 0);
      push(4'd0, 4'd1, 1, 0, 0);
      pulse_start();
      wait_user(1);
      push(4'd0, 4'd2, 1, 0, 0);
      push(4'b0001, 4'd2, 1, 0, 0);
      push(4'd0, 4'd2, 1, 0, 0);
      push(4'b0100, 4'd2, 1, 0, 0);
      push(4'd0, 4'd2, 1, 0, 0);
      press(4'b0001);
      wait_user(2);
      push(4'd0, 4'd2, 0, 1, 0);
      press(4'b0001);
      repeat (2) @(posedge clk);
      press(4'b0100);
      repeat (2) @(posedge clk);
      #1;
      check("win_set", bus.win, 1);
      check("win_round", bus.round, 2);

      // Game 3: restart from WIN, then reset mid-playback of round 2
      push(4'd0, 4'd1, 1, 0, 0);
      push(4'b0001, 4'd1, 1, 0, 0);
      push(4'd0, 4'd1, 1, 0, 0);
      pulse_start();
      check("restart_win", bus.win, 0);
      check("restart_round", bus.round, 1);
      wait_user(1);
      push(4'd0, 4'd2, 1, 0, 0);
      push(4'b0001, 4'd2, 1, 0, 0);
      press(4'b0001);
      n = 0;
      while (bus.led == 4'd0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("show_on_reached", int'(bus.led), 1);
      push(4'd0, 4'd0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_led", bus.led, 0);
      check("async_rst_round", bus.round, 0);
      check("async_rst_busy", bus.busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Game 4: round-1 playback again, then idle in USER
      push(4'd0, 4'd1, 1, 0, 0);
      push(4'b0001, 4'd1, 1, 0, 0);
      push(4'd0, 4'd1, 1, 0, 0);
      pulse_start();
      wait_user(1);
`ifdef GENIUS_TIMEOUT_EN
      push(4'd0, 4'd1, 0, 0, 1);
      repeat (20) @(posedge clk);
      #1;
      check("timeout_lose", bus.lose, 1);
      check("timeout_busy", bus.busy, 0);
`else
      repeat (400) @(posedge clk);
      #1;
      check("no_timeout_lose", bus.lose, 0);
      check("no_timeout_busy", bus.busy, 1);
`endif

      repeat (2) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
